// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, one-hot decoder state codes and sequencer FSM encoding
package cpu_pkg;
  localparam logic [3:0] OP_STA = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_STP = 4'b0100;
  localparam logic [3:0] OP_LDA = 4'b0101;
  localparam logic [3:0] OP_JMS = 4'b1000;
  localparam logic [3:0] OP_BBL = 4'b1001;
  localparam logic [3:0] OP_LDR = 4'b1110;
  localparam logic [2:0] ST_FETCH = 3'b001;
  localparam logic [2:0] ST_EXEC1 = 3'b010;
  localparam logic [2:0] ST_EXEC2 = 3'b100;
  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_FETCH = 3'd1,
    FSM_EXEC1 = 3'd2,
    FSM_EXEC2 = 3'd3,
    FSM_HALT  = 3'd4
  } fsm_t;
  function automatic logic is_load(input logic [3:0] op);
    return op == OP_LDA || op == OP_LDR;
  endfunction
endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: saturating return-stack occupancy counter with RAM address and fault detect
module stack_pointer #(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           push,
  input  logic                           pop,
  output logic [SP_W-1:0]                sp,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_addr,
  output logic                           full,
  output logic                           empty,
  output logic                           fault_evt
);
  localparam int AW = $clog2(STACK_DEPTH);
  assign full = sp == SP_W'(STACK_DEPTH);
  assign empty = sp == '0;
  assign fault_evt = en & ((push & pop) | (push & full) | (pop & empty));
  // push writes the next free slot; otherwise address the current top entry
  assign stack_addr = AW'(push ? sp : sp - SP_W'(1));
  always_ff @(posedge clk or posedge reset)
    if (reset) sp <= '0;
    else if (en && !fault_evt && (push || pop)) sp <= push ? sp + SP_W'(1) : sp - SP_W'(1);
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/exec sequencing with run/step/halt control and return-stack pointer
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           step,
  input  logic [3:0]                     inst,
  input  logic                           push,
  input  logic                           pop,
  output logic [2:0]                     state,
  output logic                           ir_load,
  output logic                           halted,
  output logic [SP_W-1:0]                sp,
  output logic [$clog2(STACK_DEPTH)-1:0] stack_addr,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           stack_fault
);
  fsm_t fsm, fsm_nx, eoi;
  logic step_mode, step_mode_nx, fault_evt;
  stack_pointer #(.STACK_DEPTH(STACK_DEPTH), .SP_W(SP_W)) u_sp (
    .clk       (clk),
    .reset     (reset),
    .en        (fsm == FSM_EXEC1),
    .push      (push),
    .pop       (pop),
    .sp        (sp),
    .stack_addr(stack_addr),
    .full      (stack_full),
    .empty     (stack_empty),
    .fault_evt (fault_evt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fsm <= FSM_IDLE;
      step_mode <= 1'b0;
      stack_fault <= 1'b0;
    end else begin
      fsm <= fsm_nx;
      step_mode <= step_mode_nx;
      stack_fault <= stack_fault | fault_evt;
    end
  always_comb begin
    eoi = run && !step_mode ? FSM_FETCH : FSM_IDLE;
    fsm_nx = fsm;
    step_mode_nx = step_mode;
    case (fsm)
      FSM_IDLE: if (run || step) begin
        fsm_nx = FSM_FETCH;
        step_mode_nx = !run;
      end
      FSM_FETCH: fsm_nx = FSM_EXEC1;
      FSM_EXEC1: fsm_nx = fault_evt || inst == OP_STP ? FSM_HALT : is_load(inst) ? FSM_EXEC2 : eoi;
      FSM_EXEC2: fsm_nx = eoi;
      default: fsm_nx = fsm;
    endcase
    // a single-stepped instruction that ends back in IDLE drops step mode
    if (fsm_nx == FSM_IDLE) step_mode_nx = 1'b0;
  end
  assign state = fsm == FSM_FETCH ? ST_FETCH : fsm == FSM_EXEC1 ? ST_EXEC1 :
                 fsm == FSM_EXEC2 ? ST_EXEC2 : 3'b000;
  assign ir_load = fsm == FSM_FETCH;
  assign halted = fsm == FSM_HALT;
endmodule
